hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage pipelined MIPS CPU.
- Sits in the EX stage alongside the ALU.
- Its hi/lo outputs feed the writeback result 4:1 select for MFHI/MFLO.
- busy drives the hazard unit to stall dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch an operation. Sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Captured with start.
- src_a  input  WIDTH  rs operand: multiplicand or dividend.
- src_b  input  WIDTH  rt operand: multiplier or divisor.
- mthi  input  1  write src_a into HI.
- mtlo  input  1  write src_a into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Reset mid-operation aborts the operation. No result is written; HI/LO are zero.
- States:
  - IDLE: start=1 at edge E0 latches op and operand magnitudes plus sign flags, counter=0, state goes to CALC. busy=1 from the cycle after E0.
  - CALC: one iteration per cycle, counter increments.
    - Multiply: shift-add on unsigned magnitudes.
    - Divide: restoring shift-subtract on magnitudes.
    - At the edge where counter reaches WIDTH-1 (edge E0+WIDTH): sign correction is applied, HI/LO are written, state returns to IDLE, busy=0, done=1.
  - done deasserts after one cycle unless a new result completes. Total latency start-edge to result-visible is WIDTH edges (32).
- Results:
  - MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient, hi = remainder.
    - Signed quotient truncates toward zero.
    - Signed remainder takes the sign of the dividend.
  - Signed magnitude of 0x80000000 is handled as unsigned 0x80000000, with no loss.
- Boundary cases:
  - Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=src_a as captured. Still takes the full latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Input conflicts:
  - start while busy: ignored, operands not captured. The hazard unit must hold the instruction.
  - mthi/mtlo in IDLE: written at the next edge and visible the following cycle. Both asserted writes src_a to both registers.
  - mthi/mtlo while busy: ignored.
  - start and mthi/mtlo together in IDLE: start wins, the move is dropped.
  - start in the same IDLE cycle that done=1: accepted. done deasserts next cycle and busy asserts.
- HI/LO change only on reset, operation completion, or an accepted move.
- Output timing: busy and done are registered with no combinational path from inputs. hi/lo are register outputs.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFD (-3), src_b=5 → busy=1 for 32 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT on the same operands → hi=0, lo=1.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234 after 32 cycles. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Conflicts:
  - mthi src_a=0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 next cycle.
  - Start MULTU 3×4; during busy assert mthi and a second start with different operands → both ignored; hi=0, lo=12 at done.
- Reset mid-operation: start DIVU 100/7, assert rst at cycle 10 → busy=0, done=0, hi=lo=0. No done pulse follows. A new start 100/7 then completes with lo=14, hi=2.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers. It sits
// in the EX stage next to the ALU. One operation takes WIDTH cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset. Aborts any operation in flight.
//   start  - launch an operation. Sampled only while idle.
//   op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Captured together with start.
//   src_a  - rs operand: multiplicand or dividend. Also the MTHI/MTLO source.
//   src_b  - rt operand: multiplier or divisor.
//   mthi   - write src_a into HI (idle only; start has priority)
//   mtlo   - write src_a into LO (idle only; start has priority)
//   busy   - operation in progress (registered)
//   done   - one-cycle pulse when HI/LO take a new result (registered)
//   hi, lo - HI/LO register outputs
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_1  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Two's-complement negate when neg is set. Negating the most negative value
  // yields the same bit pattern, which read as unsigned is its magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE_2W) : v;
  endfunction

  state_t           state_r;
  logic             is_div_r;
  logic             neg_lo_r;     // negate quotient or product: operand signs differ
  logic             neg_rem_r;    // negate remainder: dividend was negative
  logic             div_zero_r;
  logic [WIDTH-1:0] opnd_r;       // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] work_hi_r;    // product high half or partial remainder
  logic [WIDTH-1:0] work_lo_r;    // multiplier / product low half, or dividend / quotient
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH+1:0] div_diff_s;
  logic             div_borrow_s;
  logic [WIDTH-1:0] next_hi_s;
  logic [WIDTH-1:0] next_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] res_hi_s;
  logic [WIDTH-1:0] res_lo_s;

  // Operand sign flags: only the signed ops (op[0]==0) look at the top bit.
  always_comb begin
    sign_a_s = ~op[0] & src_a[WIDTH-1];
    sign_b_s = ~op[0] & src_b[WIDTH-1];
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    mul_sum_s    = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s  = {work_hi_r, work_lo_r[WIDTH-1]};
    div_diff_s   = {1'b0, div_shift_s} - {2'b00, opnd_r};
    div_borrow_s = div_diff_s[WIDTH+1];
    next_hi_s    = ZERO_W;
    next_lo_s    = ZERO_W;
    if (is_div_r) begin
      next_hi_s = div_borrow_s ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
      next_lo_s = {work_lo_r[WIDTH-2:0], ~div_borrow_s};
    end else begin
      next_hi_s = mul_sum_s[WIDTH:1];
      next_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the final step's value into the architectural result.
  // A zero divisor makes every trial subtract succeed, so the remainder
  // already equals the dividend magnitude; only the quotient is forced.
  always_comb begin
    prod_s   = cond_neg2({next_hi_s, next_lo_s}, neg_lo_r);
    res_hi_s = ZERO_W;
    res_lo_s = ZERO_W;
    if (is_div_r) begin
      res_hi_s = cond_neg(next_hi_s, neg_rem_r);
      if (div_zero_r) begin
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_lo_s = cond_neg(next_lo_s, neg_lo_r);
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      is_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      opnd_r     <= ZERO_W;
      work_hi_r  <= ZERO_W;
      work_lo_r  <= ZERO_W;
      cnt_r      <= {CW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= ZERO_W;
      lo_r       <= ZERO_W;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            is_div_r   <= op[1];
            neg_lo_r   <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            div_zero_r <= op[1] & (src_b == ZERO_W);
            opnd_r     <= cond_neg(src_b, sign_b_s);
            work_hi_r  <= ZERO_W;
            work_lo_r  <= cond_neg(src_a, sign_a_s);
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= CALC;
          end else begin
            if (mthi) begin
              hi_r <= src_a;
            end
            if (mtlo) begin
              lo_r <= src_a;
            end
          end
        end
        CALC: begin
          work_hi_r <= next_hi_s;
          work_lo_r <= next_lo_s;
          cnt_r     <= cnt_r + CNT_1;
          if (cnt_r == LAST) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vectors plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference result {hi, lo} from ordinary integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // Launch an op from idle (called away from the clock edge) and follow it to done.
  // with_move raises mthi/mtlo alongside start; inject fires mthi and a second
  // start mid-operation. Neither may change the outcome.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic with_move, input logic inject, input string tag);
    logic [63:0] res;
    logic        hold_ok;
    res     = ref_op(o, a, b);
    start   = 1'b1;
    op      = o;
    src_a   = a;
    src_b   = b;
    mthi    = with_move;
    mtlo    = with_move;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    hold_ok = (busy === 1'b1) && (done === 1'b0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      if (k < 32) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      end
      if (k == 4 && inject) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        src_a = ~a;
        src_b = b + 32'd3;
        mthi  = 1'b1;
      end
      if (k == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
    end
    check({tag, "_busy_hold"}, {63'd0, hold_ok}, 64'd1);
    check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hilo"}, {hi, lo}, res);
    exp_hi = res[63:32];
    exp_lo = res[31:0];
  endtask

  task automatic do_move(input logic h, input logic l, input logic [31:0] v, input string tag);
    mthi  = h;
    mtlo  = l;
    src_a = v;
    @(posedge clk);
    #1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    if (h) exp_hi = v;
    if (l) exp_lo = v;
    check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [4];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
    else if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
    else return $urandom;
  endfunction

  initial begin
    logic no_done;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {28'd0, busy, done, 2'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst    = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    // Directed vectors
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_m3x5");
    check("mult_m3x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mult_m1m1");
    check("mult_m1m1_const", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_m7_2");
    check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b0, "divu_7_2");
    check("divu_7_2_const", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "divu_by0");
    check("divu_by0_const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, "div_by0");
    check("div_by0_const", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

    // Moves in idle
    @(posedge clk);
    #1;
    do_move(1'b1, 1'b0, 32'hA5A5_A5A5, "mthi");
    check("mthi_const", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
    do_move(1'b0, 1'b1, 32'h1357_9BDF, "mtlo");
    do_move(1'b1, 1'b1, 32'hCAFE_F00D, "mt_both");

    // Conflicts: move with start is dropped; mthi and start while busy are ignored
    run_op(2'd1, 32'd3, 32'd4, 1'b1, 1'b1, "multu_conflict");
    check("multu_conflict_const", {hi, lo}, 64'h0000_0000_0000_000C);
    // Back-to-back: start in the done cycle
    run_op(2'd3, 32'd100, 32'd9, 1'b0, 1'b0, "b2b");

    // Reset mid-operation
    start = 1'b1;
    op    = 2'd3;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("midrst_state", {30'd0, busy, done, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    no_done = 1'b1;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("midrst_no_done", {63'd0, no_done}, 64'd1);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, "after_rst");
    check("after_rst_const", {hi, lo}, 64'h0000_0002_0000_000E);

    // Randomized operations, some back-to-back, some separated by idle cycles
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 4) == 0) begin
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rnd_move");
      end
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
